diag_loop_array: RTL and testbench

Successor diagnostic loop block for the BIST fault-localisation path of the systolic array. It supports independent `ROWS`×`COLS` geometry and programmable column/row fault thresholds. A start/busy/done handshake runs a fixed number of full rotations and drives its own row address to the eNVM. Sticky per-column, per-row and PE-count results are frozen for readout by the BIST controller.

---
 rtl/diag_pkg.sv | 22 ++
 rtl/diag_loop_chain.sv | 34 +++
 rtl/diag_loop_array.sv | 121 ++++++++++++
 tb/tb_diag_loop_array.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diag_pkg.sv
// Shared types and helpers for the diagnostic loop array.
package diag_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Widest vector popcount accepts; callers zero-extend into it.
   localparam int POP_W = 1024;

   function automatic int unsigned popcount(input logic [POP_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_W; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/diag_loop_chain.sv
// One column's loop chain: ROWS-deep shift register fed by (input | tail),
// with a detector for a run of COL_THR set stages at the tail.
module diag_loop_chain #(
   parameter int ROWS    = 8,
   parameter int COL_THR = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            step,
   input  logic            col_input,
   output logic            tail,
   output logic            tail_fault,
   output logic [ROWS-1:0] next_bits
);

   logic [ROWS-1:0] chain;

   // Value the chain takes on a step; the top uses it for the final count.
   assign next_bits  = {chain[ROWS-2:0], col_input | chain[ROWS-1]};
   assign tail       = chain[ROWS-1];
   assign tail_fault = &chain[ROWS-1 -: COL_THR];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else if (clear) begin
         chain <= '0;
      end else if (step) begin
         chain <= next_bits;
      end
   end

endmodule

// File: rtl/diag_loop_array.sv
// Diagnostic loop array: COLS recirculating fault chains rotated PASSES times,
// with sticky column/row fault maps and a final PE fault count.
module diag_loop_array
   import diag_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int COL_THR = 3,
   parameter int ROW_THR = 3,
   parameter int PASSES  = 2,
   parameter int ROW_W   = $clog2(ROWS),
   parameter int CNT_W   = $clog2(ROWS*COLS+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [COLS-1:0]  col_inputs,
   output logic             busy,
   output logic             done,
   output logic [ROW_W-1:0] row_addr,
   output logic [COLS-1:0]  single_pe_detection,
   output logic [COLS-1:0]  column_fault_detection,
   output logic [ROWS-1:0]  row_fault_detection,
   output logic [CNT_W-1:0] pe_fault_count
);

   localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

   state_t                 state;
   state_t                 state_next;
   logic [PASS_W-1:0]      pass;
   logic [COLS-1:0]        tail;
   logic [COLS-1:0]        tail_fault;
   logic [COLS-1:0]        s;
   logic [ROWS*COLS-1:0]   next_all;
   logic                   run_start;
   logic                   step;
   logic                   wrap;
   logic                   last_step;

   // abort beats start and freezes everything, so neither may act with it.
   assign run_start = start && !abort && (state != RUN);
   assign step      = (state == RUN) && in_valid && !abort;
   assign wrap      = (row_addr == ROW_W'(ROWS-1));
   assign last_step = step && wrap && (pass == PASS_W'(PASSES-1));

   assign s                   = col_inputs | tail;
   assign single_pe_detection = s;
   assign busy                = (state == RUN);
   assign done                = (state == DONE);

   for (genvar c = 0; c < COLS; c++) begin : g_col
      diag_loop_chain #(
         .ROWS    (ROWS),
         .COL_THR (COL_THR)
      ) u_chain (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear      (run_start),
         .step       (step),
         .col_input  (col_inputs[c]),
         .tail       (tail[c]),
         .tail_fault (tail_fault[c]),
         .next_bits  (next_all[c*ROWS +: ROWS])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_addr               <= '0;
         pass                   <= '0;
         column_fault_detection <= '0;
         row_fault_detection    <= '0;
         pe_fault_count         <= '0;
      end else if (run_start) begin
         row_addr               <= '0;
         pass                   <= '0;
         column_fault_detection <= '0;
         row_fault_detection    <= '0;
         pe_fault_count         <= '0;
      end else if (step) begin
         row_addr <= wrap ? '0 : row_addr + 1'b1;
         if (wrap) begin
            pass <= pass + 1'b1;
         end
         column_fault_detection <= column_fault_detection | tail_fault;
         if (int'(popcount(POP_W'(s))) >= ROW_THR) begin
            row_fault_detection[row_addr] <= 1'b1;
         end
         // Count the chains as they stand after this final step.
         if (last_step) begin
            pe_fault_count <= CNT_W'(popcount(POP_W'(next_all)));
         end
      end
   end

endmodule

// File: tb/tb_diag_loop_array.sv
// Self-checking bench for diag_loop_array against a step-level reference model.
module tb_diag_loop_array;

   localparam int ROWS    = 8;
   localparam int COLS    = 8;
   localparam int COL_THR = 3;
   localparam int ROW_THR = 3;
   localparam int PASSES  = 2;
   localparam int ROW_W   = $clog2(ROWS);
   localparam int CNT_W   = $clog2(ROWS*COLS+1);
   localparam int N       = ROWS*PASSES;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic             in_valid;
   logic [COLS-1:0]  col_inputs;
   logic             busy;
   logic             done;
   logic [ROW_W-1:0] row_addr;
   logic [COLS-1:0]  single_pe_detection;
   logic [COLS-1:0]  column_fault_detection;
   logic [ROWS-1:0]  row_fault_detection;
   logic [CNT_W-1:0] pe_fault_count;

   int checks   = 0;
   int failures = 0;

   // reference model (m_state: 0 idle, 1 run, 2 done)
   logic [COLS-1:0] m_chain[ROWS];
   logic [COLS-1:0] m_col;
   logic [ROWS-1:0] m_row;
   int              m_cnt;
   int              m_row_addr;
   int              m_pass;
   int              m_state;

   logic [COLS-1:0] stim[N];
   logic [COLS-1:0] spe_log[N];
   logic [31:0]     exp_q[$];

   diag_loop_array #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .COL_THR (COL_THR),
      .ROW_THR (ROW_THR),
      .PASSES  (PASSES)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .start                  (start),
      .abort                  (abort),
      .in_valid               (in_valid),
      .col_inputs             (col_inputs),
      .busy                   (busy),
      .done                   (done),
      .row_addr               (row_addr),
      .single_pe_detection    (single_pe_detection),
      .column_fault_detection (column_fault_detection),
      .row_fault_detection    (row_fault_detection),
      .pe_fault_count         (pe_fault_count)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int k = 0; k < ROWS; k++) m_chain[k] = '0;
      m_col      = '0;
      m_row      = '0;
      m_cnt      = 0;
      m_row_addr = 0;
      m_pass     = 0;
   endtask

   task automatic model_edge(input logic st, input logic ab, input logic iv,
                             input logic [COLS-1:0] ci);
      logic [COLS-1:0] s;
      bit allset;
      if (ab) begin
         m_state = 0;
      end else if (m_state != 1) begin
         if (st) begin
            model_clear();
            m_state = 1;
         end
      end else if (iv) begin
         s = ci | m_chain[ROWS-1];
         for (int c = 0; c < COLS; c++) begin
            allset = 1;
            for (int j = 0; j < COL_THR; j++) if (!m_chain[ROWS-1-j][c]) allset = 0;
            if (allset) m_col[c] = 1'b1;
         end
         if ($countones(s) >= ROW_THR) m_row[m_row_addr] = 1'b1;
         for (int k = ROWS-1; k > 0; k--) m_chain[k] = m_chain[k-1];
         m_chain[0] = s;
         if (m_row_addr == ROWS-1) begin
            m_row_addr = 0;
            if (m_pass == PASSES-1) begin
               m_state = 2;
               m_cnt   = 0;
               for (int k = 0; k < ROWS; k++) m_cnt += $countones(m_chain[k]);
            end
            m_pass++;
         end else begin
            m_row_addr++;
         end
      end
   endtask

   // Driver: apply inputs at the falling edge, step the model at the rising
   // edge, then compare every output with the model at the next falling edge.
   task automatic drive_cycle(input logic st, input logic ab, input logic iv,
                              input logic [COLS-1:0] ci, output logic [COLS-1:0] spe);
      logic [ROW_W-1:0] e_ra;
      logic [CNT_W-1:0] e_cnt;
      start = st; abort = ab; in_valid = iv; col_inputs = ci;
      #1;
      spe = single_pe_detection;
      checks++;
      if (spe !== (ci | m_chain[ROWS-1])) begin
         failures++;
         $display("FAIL single_pe got=%h exp=%h", spe, ci | m_chain[ROWS-1]);
      end
      @(posedge clk);
      model_edge(st, ab, iv, ci);
      @(negedge clk);
      e_ra  = m_row_addr[ROW_W-1:0];
      e_cnt = m_cnt[CNT_W-1:0];
      checks++;
      if ({busy, done} !== {m_state == 1, m_state == 2}) begin
         failures++;
         $display("FAIL busy_done got=%b%b exp=%b%b", busy, done, m_state == 1, m_state == 2);
      end
      checks++;
      if (row_addr !== e_ra) begin
         failures++;
         $display("FAIL row_addr got=%0d exp=%0d", row_addr, e_ra);
      end
      checks++;
      if (column_fault_detection !== m_col) begin
         failures++;
         $display("FAIL col_map got=%h exp=%h", column_fault_detection, m_col);
      end
      checks++;
      if (row_fault_detection !== m_row) begin
         failures++;
         $display("FAIL row_map got=%h exp=%h", row_fault_detection, m_row);
      end
      checks++;
      if (pe_fault_count !== e_cnt) begin
         failures++;
         $display("FAIL pe_count got=%0d exp=%0d", pe_fault_count, e_cnt);
      end
   endtask

   // gap_mode: 0 = in_valid held high, 1 = alternating starting low, 2 = random
   task automatic run_stim(input int gap_mode, output int run_cycles);
      int idx;
      int guard;
      logic iv;
      logic st;
      logic [COLS-1:0] ci;
      logic [COLS-1:0] spe;
      idx = 0;
      guard = 0;
      run_cycles = 0;
      drive_cycle(1'b1, 1'b0, 1'b0, '0, spe);
      while (idx < N && guard < 400) begin
         case (gap_mode)
            0:       iv = 1'b1;
            1:       iv = (guard % 2 == 1);
            default: iv = 1'($urandom_range(0, 1));
         endcase
         st = (gap_mode == 2) && ($urandom_range(0, 7) == 0);
         ci = iv ? stim[idx] : COLS'($urandom);
         if (busy) run_cycles++;
         drive_cycle(st, 1'b0, iv, ci, spe);
         if (iv) begin
            spe_log[idx] = spe;
            idx++;
         end
         guard++;
      end
      checks++;
      if (guard >= 400) begin
         failures++;
         $display("FAIL run_timeout got=%0d steps exp=%0d", idx, N);
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL run_done got=%b exp=1", done);
      end
   endtask

   task automatic fill_sparse();
      for (int i = 0; i < N; i++) stim[i] = COLS'($urandom & $urandom & $urandom);
   endtask

   task automatic fill_zero();
      for (int i = 0; i < N; i++) stim[i] = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      col_inputs = COLS'($urandom);
      model_clear();
      m_state = 0;
      #3;
      checks++;
      if ({busy, done, row_addr} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b%b%h exp=0", busy, done, row_addr);
      end
      checks++;
      if ({column_fault_detection, row_fault_detection, pe_fault_count} !== '0) begin
         failures++;
         $display("FAIL reset_maps got=%h/%h/%0d exp=0", column_fault_detection,
                  row_fault_detection, pe_fault_count);
      end
      checks++;
      if (single_pe_detection !== col_inputs) begin
         failures++;
         $display("FAIL reset_spe got=%h exp=%h", single_pe_detection, col_inputs);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_zero_run();
      int rc;
      fill_zero();
      run_stim(0, rc);
      checks++;
      if (rc !== ROWS*PASSES) begin
         failures++;
         $display("FAIL zero_run_len got=%0d exp=%0d", rc, ROWS*PASSES);
      end
      checks++;
      if ({column_fault_detection, row_fault_detection, pe_fault_count} !== '0) begin
         failures++;
         $display("FAIL zero_run_res got=%h/%h/%0d exp=0", column_fault_detection,
                  row_fault_detection, pe_fault_count);
      end
   endtask

   task automatic test_single_pe();
      int rc;
      fill_zero();
      stim[2] = 8'h01;
      run_stim(0, rc);
      checks++;
      if ({spe_log[ROWS+1][0], spe_log[ROWS+2][0]} !== 2'b01) begin
         failures++;
         $display("FAIL single_pe_loop got=%b%b exp=01", spe_log[ROWS+1][0], spe_log[ROWS+2][0]);
      end
      checks++;
      if (pe_fault_count !== CNT_W'(1) || column_fault_detection !== '0) begin
         failures++;
         $display("FAIL single_pe_res got=%0d/%h exp=1/00", pe_fault_count, column_fault_detection);
      end
   endtask

   task automatic test_col_fault();
      int rc;
      fill_zero();
      stim[5] = 8'h20; stim[6] = 8'h20; stim[7] = 8'h20;
      run_stim(0, rc);
      checks++;
      if (column_fault_detection !== 8'h20 || pe_fault_count !== CNT_W'(3)) begin
         failures++;
         $display("FAIL col_fault got=%h/%0d exp=20/3", column_fault_detection, pe_fault_count);
      end
   endtask

   task automatic test_row_fault();
      int rc;
      fill_zero();
      stim[4] = 8'h07;
      run_stim(0, rc);
      checks++;
      if (row_fault_detection !== 8'h10) begin
         failures++;
         $display("FAIL row_fault_07 got=%h exp=10", row_fault_detection);
      end
      stim[4] = 8'h03;
      run_stim(0, rc);
      checks++;
      if (row_fault_detection !== 8'h00 || pe_fault_count !== CNT_W'(2)) begin
         failures++;
         $display("FAIL row_fault_03 got=%h/%0d exp=00/2", row_fault_detection, pe_fault_count);
      end
   endtask

   task automatic test_stall();
      int rc;
      logic [31:0] e_col, e_row, e_cnt;
      fill_sparse();
      run_stim(0, rc);
      exp_q.push_back(32'(m_col));
      exp_q.push_back(32'(m_row));
      exp_q.push_back(32'(m_cnt));
      run_stim(1, rc);
      checks++;
      if (rc !== 2*ROWS*PASSES) begin
         failures++;
         $display("FAIL stall_len got=%0d exp=%0d", rc, 2*ROWS*PASSES);
      end
      e_col = exp_q.pop_front();
      e_row = exp_q.pop_front();
      e_cnt = exp_q.pop_front();
      checks++;
      if ({column_fault_detection, row_fault_detection, pe_fault_count} !==
          {e_col[COLS-1:0], e_row[ROWS-1:0], e_cnt[CNT_W-1:0]}) begin
         failures++;
         $display("FAIL stall_res got=%h/%h/%0d exp=%h/%h/%0d", column_fault_detection,
                  row_fault_detection, pe_fault_count, e_col, e_row, e_cnt);
      end
   endtask

   task automatic test_abort();
      logic [COLS-1:0] spe;
      logic [COLS-1:0] held_col;
      logic [ROWS-1:0] held_row;
      fill_sparse();
      stim[0] = 8'hff; stim[1] = 8'hff; stim[2] = 8'hff;
      drive_cycle(1'b1, 1'b0, 1'b0, '0, spe);
      for (int i = 0; i < ROWS + 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, stim[i], spe);
      held_col = m_col;
      held_row = m_row;
      drive_cycle(1'b0, 1'b1, 1'b1, stim[ROWS+3], spe);
      checks++;
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("FAIL abort_ctrl got=%b%b exp=00", busy, done);
      end
      checks++;
      if (column_fault_detection !== held_col || row_fault_detection !== held_row) begin
         failures++;
         $display("FAIL abort_hold got=%h/%h exp=%h/%h", column_fault_detection,
                  row_fault_detection, held_col, held_row);
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'($urandom), COLS'($urandom), spe);
      drive_cycle(1'b1, 1'b1, 1'b1, 8'hff, spe);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_abort got=%b exp=0", busy);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, '0, spe);
      checks++;
      if ({busy, row_addr, column_fault_detection, row_fault_detection, pe_fault_count} !==
          {1'b1, {(ROW_W+COLS+ROWS+CNT_W){1'b0}}}) begin
         failures++;
         $display("FAIL restart_clear got=%b/%0d/%h/%h/%0d exp=1/0/00/00/0", busy, row_addr,
                  column_fault_detection, row_fault_detection, pe_fault_count);
      end
      for (int i = 0; i < N; i++) drive_cycle(1'b0, 1'b0, 1'b1, stim[i], spe);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL restart_done got=%b exp=1", done);
      end
   endtask

   task automatic test_back_to_back();
      int rc;
      for (int r = 0; r < 4; r++) begin
         fill_sparse();
         run_stim(2, rc);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [COLS-1:0] spe;
      fill_sparse();
      drive_cycle(1'b1, 1'b0, 1'b0, '0, spe);
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, 8'hff, spe);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      m_state = 0;
      checks++;
      if ({busy, done, row_addr, column_fault_detection, row_fault_detection, pe_fault_count} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%b%b/%0d/%h/%h/%0d exp=0", busy, done, row_addr,
                  column_fault_detection, row_fault_detection, pe_fault_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b0, 1'b0, 1'b1, 8'hff, spe);
   endtask

   initial begin
      test_reset();
      test_zero_run();
      test_single_pe();
      test_col_fault();
      test_row_fault();
      test_stall();
      test_abort();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
